// File: rtl/dsp_result_drain_if.sv
// Handshake bundle between the DSP result drain and its environment.
// master: the side that issues ops, feeds the DSP P output and consumes results.
// slave:  the drain block itself.
interface dsp_result_drain_if #(
  parameter int F     = 48,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          issue_valid;
  logic          issue_ready;
  logic [F-1:0]  p_in;
  logic          out_valid;
  logic          out_ready;
  logic [F-1:0]  out_data;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;

  modport master (
    output issue_valid, p_in, out_ready,
    input  issue_ready, out_valid, out_data, occupancy, inflight
  );

  modport slave (
    input  issue_valid, p_in, out_ready,
    output issue_ready, out_valid, out_data, occupancy, inflight
  );
endinterface

// File: rtl/dsp_result_drain.sv
// dsp_result_drain: collects results of a fixed-latency, never-stalling DSP
// pipeline into a FIFO and presents them over valid/ready. Issue is throttled
// by credits (inflight + occupancy < DEPTH) so a landing result always finds
// a free FIFO slot and the DSP pipeline never needs to stall.
// Optional feature: define DSP_DRAIN_BYPASS_EN to forward a landing result
// straight to the consumer when the FIFO is empty (saves one cycle).
// LATENCY legal range 1..16; DEPTH a power of two, >= 2.
module dsp_result_drain #(
  parameter int F       = 48,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input logic          clk,
  input logic          reset_n,
  dsp_result_drain_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] tag_pipe;
  logic [F-1:0]       mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      occ, infl;
  logic [CW:0]        used;
  logic               acc, land, wr, fifo_pop;

  // Credits: every accepted issue owns a FIFO slot until its result is popped.
  assign used            = {1'b0, infl} + {1'b0, occ};
  assign bus.issue_ready = used < (CW+1)'(DEPTH);
  assign acc             = bus.issue_valid && bus.issue_ready;
  assign land            = tag_pipe[LATENCY-1];
  assign fifo_pop        = (occ != '0) && bus.out_ready;

`ifdef DSP_DRAIN_BYPASS_EN
  logic byp;
  // Empty FIFO + landing result: show p_in directly; if taken, skip the write.
  assign byp           = (occ == '0) && land;
  assign wr            = land && !(byp && bus.out_ready);
  assign bus.out_valid = (occ != '0) || byp;
  assign bus.out_data  = byp ? bus.p_in : mem[rd_ptr];
`else
  assign wr            = land;
  assign bus.out_valid = (occ != '0);
  assign bus.out_data  = mem[rd_ptr];
`endif

  assign bus.occupancy = occ;
  assign bus.inflight  = infl;

  // Tag delay line: one bit per issue slot, tail marks the landing cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= acc;
      for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Result storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= bus.p_in;
  end

  // Pointers and counters; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      infl   <= '0;
    end else begin
      if (wr)       wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({acc, land})
        2'b10:   infl <= infl + CW'(1);
        2'b01:   infl <= infl - CW'(1);
        default: infl <= infl;
      endcase
      case ({wr, fifo_pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_dsp_result_drain.sv
// Scoreboard bench for dsp_result_drain. The driver models the DSP pipeline
// (delivers each op's result on p_in in its landing cycle) and tracks
// issued/landed/popped totals from which credits and counters follow;
// a separate monitor pops expected results whenever the DUT hands one over.
module tb_dsp_result_drain;
  localparam int F = 48, LATENCY = 4, DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef DSP_DRAIN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct { int when; logic [F-1:0] data; } op_t;

  logic clk = 1'b0, reset_n;
  always #5 clk = ~clk;

  dsp_result_drain_if #(.F(F), .DEPTH(DEPTH)) bus ();
  dsp_result_drain #(.F(F), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int vectors = 0, errors = 0;
  int edge_n = 0, issued = 0, landed = 0, popped = 0;
  op_t sched[$];
  logic [F-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [F-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[F-1:0];
  endfunction

  // One clock cycle, entered just after a falling edge.
  task automatic cycle(input logic iv, input logic ordy, input logic [F-1:0] d);
    bit land_now, exp_ready, exp_valid, acc, pop;
    bus.issue_valid = iv;
    bus.out_ready   = ordy;
    land_now = (sched.size() > 0) && (sched[0].when == edge_n);
    bus.p_in = land_now ? sched[0].data : rnd_data();
    #1;
    exp_ready = (issued - popped) < DEPTH;
    exp_valid = (landed != popped) || (BYP && land_now);
    chk("issue_ready", 64'(bus.issue_ready), 64'(exp_ready));
    chk("out_valid",   64'(bus.out_valid),   64'(exp_valid));
    chk("occupancy",   64'(bus.occupancy),   64'(landed - popped));
    chk("inflight",    64'(bus.inflight),    64'(issued - landed));
    acc = iv && exp_ready;
    pop = exp_valid && ordy;
    if (acc) begin
      sched.push_back('{when: edge_n + LATENCY, data: d});
      exp_q.push_back(d);
      issued++;
    end
    if (land_now) begin
      void'(sched.pop_front());
      landed++;
    end
    if (pop) popped++;
    @(negedge clk);
    edge_n++;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || sched.size() > 0) && n < 200) begin
      cycle(1'b0, 1'b1, '0);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
    end
  endtask

  // Monitor: every accepted output must match the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL spurious_out: got %0h expected no result", bus.out_data);
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.p_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid",   64'(bus.out_valid),   64'd0);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_occupancy",   64'(bus.occupancy),   64'd0);
    chk("rst_inflight",    64'(bus.inflight),    64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single op.
    cycle(1'b1, 1'b1, 48'h0000_1234_5678);
    repeat (LATENCY + 2) cycle(1'b0, 1'b1, '0);

    // Backpressure: credits cap acceptance at DEPTH, then release in order.
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, F'(issued));
    chk("bp_occupancy", 64'(bus.occupancy), 64'(DEPTH));
    chk("bp_inflight",  64'(bus.inflight),  64'd0);
    drain();

    // Streaming: full throughput, occupancy stays at most 1.
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b1, F'(i));
      vectors++;
      if (bus.occupancy > CW'(1)) begin
        errors++;
        $display("FAIL stream_occ: got %0d expected <= 1", bus.occupancy);
      end
    end
    drain();

    // Random traffic with bursty backpressure.
    for (int i = 0; i < 400; i++) begin
      int bias = (i / 50) % 4;
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) >= bias), rnd_data());
    end
    drain();

    // Mid-operation reset with inflight=3, occupancy=2.
    repeat (5) cycle(1'b1, 1'b0, rnd_data());
    cycle(1'b0, 1'b0, '0);
    chk("pre_rst_occ",  64'(bus.occupancy), 64'd2);
    chk("pre_rst_infl", 64'(bus.inflight),  64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid",   64'(bus.out_valid),   64'd0);
    chk("mid_rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("mid_rst_occupancy",   64'(bus.occupancy),   64'd0);
    chk("mid_rst_inflight",    64'(bus.inflight),    64'd0);
    sched.delete();
    exp_q.delete();
    issued = 0;
    landed = 0;
    popped = 0;
    @(negedge clk);
    #3;
    reset_n = 1'b1;
    @(negedge clk);
    edge_n += 2;
    // Discarded results must never show up.
    repeat (2 * LATENCY) cycle(1'b0, 1'b1, '0);

    // Post-reset sanity traffic.
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'($urandom_range(0, 1)), rnd_data());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
